// File: rtl/nmcu_instr_ingress_fifo_if.sv
// Valid/ready instruction stream carrying one packed instruction word per beat.
// The master side owns valid and instr; the slave side owns ready.
interface nmcu_instr_ingress_fifo_if #(
  parameter int INSTR_W = 64
);
  logic               valid;
  logic               ready;
  logic [INSTR_W-1:0] instr;

  modport master (
    output valid,
    output instr,
    input  ready
  );

  modport slave (
    input  valid,
    input  instr,
    output ready
  );
endinterface

// File: rtl/nmcu_instr_ingress_fifo.sv
// Instruction ingress queue between the chiplet interconnect and the NMCU decoder.
// Holds up to DEPTH instructions, applies real backpressure upstream, presents
// entries in order downstream one cycle after they are accepted, and latches a
// sticky error when the upstream side breaks the valid/ready hold rule.
module nmcu_instr_ingress_fifo #(
  parameter int DEPTH    = 4,
  parameter int INSTR_W  = 64,
  parameter int AF_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  nmcu_instr_ingress_fifo_if.slave   in_bus,
  nmcu_instr_ingress_fifo_if.master  out_bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [INSTR_W-1:0] mem [DEPTH];

  logic [PW-1:0]      wr_ptr, wr_ptr_next;
  logic [PW-1:0]      rd_ptr, rd_ptr_next;
  logic [CW-1:0]      count_next;
  logic               almost_full_next;
  logic               stalled_q, stalled_next;
  logic [INSTR_W-1:0] held_instr_q;
  logic               proto_err_next;
  logic               proto_viol;

  logic               in_ready_int;
  logic               out_valid_int;
  logic               push;
  logic               pop;

  // Handshake flags come straight from the registered occupancy, so neither
  // ready nor valid has a combinational path from the opposite side.
  assign in_ready_int  = (count != DEPTH_C);
  assign out_valid_int = (count != '0);
  assign push          = in_bus.valid & in_ready_int;
  assign pop           = out_valid_int & out_bus.ready;

  assign in_bus.ready  = in_ready_int;
  assign out_bus.valid = out_valid_int;
  // The storage is never cleared, so the head word is masked to zero while
  // the queue is empty to keep stale data off the decoder bus.
  assign out_bus.instr = out_valid_int ? mem[rd_ptr] : '0;

  // A beat that stalled last cycle must be re-presented unchanged this cycle.
  assign proto_viol = stalled_q &
                      (!in_bus.valid || (in_bus.instr != held_instr_q));

  // Next-state for pointers, occupancy and status flags; flush discards any
  // push or pop that coincides with it.
  always_comb begin
    wr_ptr_next      = wr_ptr;
    rd_ptr_next      = rd_ptr;
    count_next       = count;
    almost_full_next = 1'b0;
    stalled_next     = in_bus.valid & ~in_ready_int;
    proto_err_next   = proto_err | proto_viol;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end

    almost_full_next = (count_next >= AF_C);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      almost_full  <= 1'b0;
      stalled_q    <= 1'b0;
      held_instr_q <= '0;
      proto_err    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      count        <= count_next;
      almost_full  <= almost_full_next;
      stalled_q    <= stalled_next;
      held_instr_q <= in_bus.instr;
      proto_err    <= proto_err_next;
    end
  end

  // Entry storage, written on an accepted push that is not being flushed.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= in_bus.instr;
    end
  end

endmodule

// File: tb/tb_nmcu_instr_ingress_fifo.sv
// Directed bench for the instruction ingress FIFO (DEPTH=4, AF_LEVEL=3).
module tb_nmcu_instr_ingress_fifo;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       almost_full;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  nmcu_instr_ingress_fifo_if #(.INSTR_W(64)) in_bus ();
  nmcu_instr_ingress_fifo_if #(.INSTR_W(64)) out_bus ();

  nmcu_instr_ingress_fifo #(
    .DEPTH   (4),
    .INSTR_W (64),
    .AF_LEVEL(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_bus     (in_bus),
    .out_bus    (out_bus),
    .count      (count),
    .almost_full(almost_full),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [63:0] v);
    in_bus.valid = 1'b1;
    in_bus.instr = v;
    tick();
    in_bus.valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    in_bus.valid  = 1'b0;
    in_bus.instr  = '0;
    out_bus.ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_bus.ready), 64'd1);
    chk("rst_out_valid", 64'(out_bus.valid), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    chk("rst_out_instr", out_bus.instr, 64'd0);

    // 1: single push, one cycle latency
    in_bus.valid = 1'b1;
    in_bus.instr = 64'hA1;
    chk("t1_no_fallthrough", 64'(out_bus.valid), 64'd0);
    tick();
    in_bus.valid = 1'b0;
    chk("t1_out_valid", 64'(out_bus.valid), 64'd1);
    chk("t1_out_instr", out_bus.instr, 64'hA1);
    chk("t1_count", 64'(count), 64'd1);
    out_bus.ready = 1'b1;
    tick();
    out_bus.ready = 1'b0;
    chk("t1_drained", 64'(count), 64'd0);
    chk("t1_empty", 64'(out_bus.valid), 64'd0);

    // 2: fill to DEPTH, stall a fifth beat, drain in order
    push_one(64'h1);
    push_one(64'h2);
    chk("t2_count2", 64'(count), 64'd2);
    chk("t2_af_at2", 64'(almost_full), 64'd0);
    push_one(64'h3);
    chk("t2_count3", 64'(count), 64'd3);
    chk("t2_af_at3", 64'(almost_full), 64'd1);
    push_one(64'h4);
    chk("t2_count4", 64'(count), 64'd4);
    chk("t2_in_ready_full", 64'(in_bus.ready), 64'd0);
    chk("t2_af_at4", 64'(almost_full), 64'd1);
    in_bus.valid = 1'b1;
    in_bus.instr = 64'h5;
    tick();
    chk("t2_stalled_count", 64'(count), 64'd4);
    // drain while the stalled beat is held steady; it enters after the first pop
    out_bus.ready = 1'b1;
    chk("t2_out1", out_bus.instr, 64'h1);
    tick();
    chk("t2_count_after_pop", 64'(count), 64'd3);
    chk("t2_out2", out_bus.instr, 64'h2);
    tick();
    in_bus.valid = 1'b0;
    chk("t2_count_pushpop", 64'(count), 64'd3);
    chk("t2_out3", out_bus.instr, 64'h3);
    tick();
    chk("t2_out4", out_bus.instr, 64'h4);
    tick();
    chk("t2_out5", out_bus.instr, 64'h5);
    tick();
    out_bus.ready = 1'b0;
    chk("t2_count_end", 64'(count), 64'd0);
    chk("t2_perr_clean", 64'(proto_err), 64'd0);

    // 3: steady push+pop at count 2 with wrapping pointers
    push_one(64'h10);
    push_one(64'h11);
    in_bus.valid  = 1'b1;
    out_bus.ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_bus.instr = 64'h12 + 64'(k);
      chk("t3_stream_out", out_bus.instr, 64'h10 + 64'(k));
      chk("t3_stream_count", 64'(count), 64'd2);
      tick();
    end
    in_bus.valid = 1'b0;
    chk("t3_tail0", out_bus.instr, 64'h1A);
    tick();
    chk("t3_tail1", out_bus.instr, 64'h1B);
    tick();
    out_bus.ready = 1'b0;
    chk("t3_count_end", 64'(count), 64'd0);

    // 4: full, push and pop together -> only the pop happens
    push_one(64'h21);
    push_one(64'h22);
    push_one(64'h23);
    push_one(64'h24);
    in_bus.valid  = 1'b1;
    in_bus.instr  = 64'h25;
    out_bus.ready = 1'b1;
    chk("t4_in_ready", 64'(in_bus.ready), 64'd0);
    chk("t4_head", out_bus.instr, 64'h21);
    tick();
    out_bus.ready = 1'b0;
    chk("t4_count3", 64'(count), 64'd3);
    chk("t4_head2", out_bus.instr, 64'h22);
    tick();
    in_bus.valid = 1'b0;
    chk("t4_count4", 64'(count), 64'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_count", 64'(count), 64'd0);
    chk("t4_flush_af", 64'(almost_full), 64'd0);
    chk("t4_perr_clean", 64'(proto_err), 64'd0);

    // 5: flush discards a coincident push
    push_one(64'h31);
    push_one(64'h32);
    push_one(64'h33);
    chk("t5_count3", 64'(count), 64'd3);
    flush        = 1'b1;
    in_bus.valid = 1'b1;
    in_bus.instr = 64'h34;
    tick();
    flush        = 1'b0;
    in_bus.valid = 1'b0;
    chk("t5_count0", 64'(count), 64'd0);
    chk("t5_out_valid", 64'(out_bus.valid), 64'd0);
    chk("t5_af", 64'(almost_full), 64'd0);
    chk("t5_in_ready", 64'(in_bus.ready), 64'd1);
    push_one(64'h41);
    chk("t5_lost_count", 64'(count), 64'd1);
    chk("t5_lost_head", out_bus.instr, 64'h41);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // 6: payload change while stalled sets a sticky error
    push_one(64'h51);
    push_one(64'h52);
    push_one(64'h53);
    push_one(64'h54);
    in_bus.valid = 1'b1;
    in_bus.instr = 64'hBB;
    tick();
    chk("t6_perr_before", 64'(proto_err), 64'd0);
    in_bus.instr = 64'hCC;
    tick();
    in_bus.valid = 1'b0;
    chk("t6_perr_set", 64'(proto_err), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_perr_after_flush", 64'(proto_err), 64'd1);
    chk("t6_flush_count", 64'(count), 64'd0);
    push_one(64'h61);
    chk("t6_count1", 64'(count), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_perr_rst", 64'(proto_err), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_out_valid", 64'(out_bus.valid), 64'd0);
    chk("t6_rst_out_instr", out_bus.instr, 64'd0);

    // dropping valid while stalled also flags the error
    push_one(64'h71);
    push_one(64'h72);
    push_one(64'h73);
    push_one(64'h74);
    in_bus.valid = 1'b1;
    in_bus.instr = 64'h75;
    tick();
    in_bus.valid = 1'b0;
    tick();
    chk("t7_perr_drop", 64'(proto_err), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
